// File: rtl/aclint_multi_hart_pkg.sv
// Shared constants, types and helpers for the multi-hart ACLINT timer/software-interrupt device.
package aclint_multi_hart_pkg;

  localparam int XLEN = 64;

  typedef logic [63:0] UInt64;

  localparam UInt64 MMAP_ACLINT_BASE    = 64'h0000_0000_0200_0000;
  localparam UInt64 ACLINT_MSIP_OFS     = 64'h0000_0000_0000_0000;
  localparam UInt64 ACLINT_MTIMECMP_OFS = 64'h0000_0000_0000_4000;
  localparam UInt64 ACLINT_MTIME_OFS    = 64'h0000_0000_0000_BFF8;
  localparam int    ACLINT_MAX_HARTS    = 32;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } aclint_reg_e;

  // idx is the MSIP doubleword (2 harts each) or the MTIMECMP hart number.
  typedef struct packed {
    aclint_reg_e kind;
    logic [4:0]  idx;
  } aclint_dec_t;

  function automatic UInt64 wmask_expand(input logic [7:0] wmask);
    UInt64 m;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{wmask[i]}};
    return m;
  endfunction

  // Offset is relative to the device base; bits [2:0] never take part in decode.
  function automatic aclint_dec_t aclint_decode(input UInt64 ofs, input int unsigned harts);
    aclint_dec_t d;
    d.kind = REG_NONE;
    d.idx  = '0;
    if (ofs[63:7] == ACLINT_MSIP_OFS[63:7] && 32'({ofs[6:3], 1'b0}) < harts) begin
      d.kind = REG_MSIP;
      d.idx  = {1'b0, ofs[6:3]};
    end else if (ofs[63:8] == ACLINT_MTIMECMP_OFS[63:8] && 32'(ofs[7:3]) < harts) begin
      d.kind = REG_MTIMECMP;
      d.idx  = ofs[7:3];
    end else if (ofs[63:3] == ACLINT_MTIME_OFS[63:3]) begin
      d.kind = REG_MTIME;
    end
    return d;
  endfunction

endpackage

// File: rtl/aclint_multi_hart_if.sv
// Membus request/response bundle: single-beat 64-bit accesses with byte write mask.
interface aclint_multi_hart_if;
  import aclint_multi_hart_pkg::*;

  logic       valid;
  logic       ready;
  UInt64      addr;
  logic       wen;
  UInt64      wdata;
  logic [7:0] wmask;
  logic       rvalid;
  UInt64      rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/aclint_multi_hart_mtime_counter.sv
// Shared mtime: prescaled free-running 64-bit counter with a byte-masked software write port.
module aclint_mtime_counter
  import aclint_multi_hart_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en_i,
  input  UInt64 wr_data_i,
  input  UInt64 wr_mask_i,
  output UInt64 mtime_o
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  UInt64         mtime_q, mtime_d;
  logic          tick;

  assign tick    = (presc_q == PRESC_LAST);
  assign mtime_o = mtime_q;

  // NOTE: both next-state values get a full default before the override, so no latch is inferred.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A software write wins over a coincident tick and restarts the prescale period.
    if (wr_en_i) begin
      presc_d = '0;
      mtime_d = (wr_data_i & wr_mask_i) | (mtime_q & ~wr_mask_i);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

endmodule

// File: rtl/aclint_multi_hart.sv
// ACLINT MSWI/MTIMER for HART_NUM harts on Membus: per-hart msip and mtimecmp, shared mtime.
module aclint_multi_hart
  import aclint_multi_hart_pkg::*;
#(
  parameter int unsigned HART_NUM  = 1,
  parameter int unsigned TICK_DIV  = 1,
  parameter UInt64       BASE_ADDR = MMAP_ACLINT_BASE
) (
  input  logic                clk,
  input  logic                rst,
  aclint_multi_hart_if.slave  membus,
  output logic [HART_NUM-1:0] msip,
  output logic [HART_NUM-1:0] mtip
);

  UInt64                       ofs;
  aclint_dec_t                 dec;
  logic                        wr_en;
  logic                        rd_en;
  UInt64                       wr_mask;
  UInt64                       mtime;
  UInt64                       mtimecmp_q [HART_NUM];
  UInt64                       mtimecmp_d [HART_NUM];
  logic [HART_NUM-1:0]         msip_q, msip_d;
  logic [ACLINT_MAX_HARTS-1:0] msip_pad;
  logic                        rvalid_q;
  UInt64                       rdata_q, rdata_d;

  assign ofs           = membus.addr - BASE_ADDR;
  assign dec           = aclint_decode(ofs, HART_NUM);
  assign wr_en         = membus.valid & membus.wen;
  assign rd_en         = membus.valid & ~membus.wen;
  assign wr_mask       = wmask_expand(membus.wmask);
  assign msip_pad      = ACLINT_MAX_HARTS'(msip_q);
  assign membus.ready  = 1'b1;
  assign membus.rvalid = rvalid_q;
  assign membus.rdata  = rdata_q;
  assign msip          = msip_q;

  aclint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en && dec.kind == REG_MTIME),
    .wr_data_i (membus.wdata),
    .wr_mask_i (wr_mask),
    .mtime_o   (mtime)
  );

  // Hart h sits in doubleword h/2, lane h%2; only byte 0 of a lane carries the msip bit.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    for (int h = 0; h < int'(HART_NUM); h++) begin
      if (wr_en && dec.kind == REG_MTIMECMP && dec.idx == 5'(h))
        mtimecmp_d[h] = (membus.wdata & wr_mask) | (mtimecmp_q[h] & ~wr_mask);
      if (wr_en && dec.kind == REG_MSIP && dec.idx == 5'(h / 2) && membus.wmask[(h % 2) * 4])
        msip_d[h] = membus.wdata[(h % 2) * 32];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (dec.kind)
        REG_MSIP:
          rdata_d = {31'b0, msip_pad[{dec.idx[3:0], 1'b1}], 31'b0, msip_pad[{dec.idx[3:0], 1'b0}]};
        REG_MTIMECMP:
          for (int h = 0; h < int'(HART_NUM); h++)
            if (dec.idx == 5'(h)) rdata_d = mtimecmp_q[h];
        REG_MTIME:
          rdata_d = mtime;
        default: ;
      endcase
    end
  end

  always_comb begin
    mtip = '0;
    for (int h = 0; h < int'(HART_NUM); h++) mtip[h] = (mtime >= mtimecmp_q[h]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      msip_q   <= '0;
      // NOTE: the compare array is reset on purpose: all-ones keeps mtip low until software arms it.
      for (int h = 0; h < int'(HART_NUM); h++) mtimecmp_q[h] <= '1;
    end else begin
      rvalid_q <= membus.valid;
      rdata_q  <= rdata_d;
      msip_q   <= msip_d;
      for (int h = 0; h < int'(HART_NUM); h++) mtimecmp_q[h] <= mtimecmp_d[h];
    end
  end

endmodule

// File: tb/tb_aclint_multi_hart.sv
// Directed bench: a 4-hart/div-4 instance for the main map and prescaler, a 3-hart/div-1 one for wrap.
module tb_aclint_multi_hart;
  import aclint_multi_hart_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic       clk;
  logic       rst;
  logic [3:0] msip0, mtip0;
  logic [2:0] msip1, mtip1;

  int errors = 0;
  int checks = 0;

  aclint_multi_hart_if bus0 ();
  aclint_multi_hart_if bus1 ();

  aclint_multi_hart #(.HART_NUM(4), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .membus(bus0), .msip(msip0), .mtip(mtip0)
  );

  aclint_multi_hart #(.HART_NUM(3), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .membus(bus1), .msip(msip1), .mtip(mtip1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one request and returns at the next negedge with the response.
  task automatic op(input int which, input logic wen, input logic [63:0] ofs,
                    input logic [63:0] wdata, input logic [7:0] wmask,
                    output logic rv, output logic [63:0] rd);
    if (which == 0) begin
      bus0.valid = 1'b1; bus0.wen = wen; bus0.addr = MMAP_ACLINT_BASE + ofs;
      bus0.wdata = wdata; bus0.wmask = wmask;
    end else begin
      bus1.valid = 1'b1; bus1.wen = wen; bus1.addr = MMAP_ACLINT_BASE + ofs;
      bus1.wdata = wdata; bus1.wmask = wmask;
    end
    @(negedge clk);
    if (which == 0) begin
      rv = bus0.rvalid; rd = bus0.rdata; bus0.valid = 1'b0;
    end else begin
      rv = bus1.rvalid; rd = bus1.rdata; bus1.valid = 1'b0;
    end
  endtask

  task automatic wr(input int which, input string name, input logic [63:0] ofs,
                    input logic [63:0] wdata, input logic [7:0] wmask);
    logic rv;
    logic [63:0] rd;
    op(which, 1'b1, ofs, wdata, wmask, rv, rd);
    check({name, "_rvalid"}, 64'(rv), 64'd1);
  endtask

  task automatic rd_chk(input int which, input string name, input logic [63:0] ofs,
                        input logic [63:0] exp);
    logic rv;
    logic [63:0] rd;
    op(which, 1'b0, ofs, '0, '0, rv, rd);
    check({name, "_rvalid"}, 64'(rv), 64'd1);
    check({name, "_rdata"}, rd, exp);
  endtask

  typedef struct {
    logic        wen;
    logic [63:0] ofs;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic [3:0]  exp_msip;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  initial begin
    logic        rv;
    logic [63:0] rd;

    vec[0]  = '{1'b0, 64'h4000, 64'h0, 8'h00, ONES, 4'h0};
    vec[1]  = '{1'b0, 64'h4008, 64'h0, 8'h00, ONES, 4'h0};
    vec[2]  = '{1'b0, 64'h4010, 64'h0, 8'h00, ONES, 4'h0};
    vec[3]  = '{1'b0, 64'h4018, 64'h0, 8'h00, ONES, 4'h0};
    vec[4]  = '{1'b1, 64'h0000, 64'h1_0000_0001, 8'hF0, 64'h0, 4'h2};
    vec[5]  = '{1'b0, 64'h0000, 64'h0, 8'h00, 64'h1_0000_0000, 4'h2};
    vec[6]  = '{1'b1, 64'h0008, 64'h1_0000_0001, 8'h01, 64'h0, 4'h6};
    vec[7]  = '{1'b0, 64'h000C, 64'h0, 8'h00, 64'h0000_0000_0000_0001, 4'h6};
    vec[8]  = '{1'b1, 64'h0000, ONES, 8'h0F, 64'h0, 4'h7};
    vec[9]  = '{1'b0, 64'h0004, 64'h0, 8'h00, 64'h1_0000_0001, 4'h7};
    vec[10] = '{1'b1, 64'h4008, 64'h0000_0000_1234_5678, 8'h0F, 64'h0, 4'h7};
    vec[11] = '{1'b0, 64'h4008, 64'h0, 8'h00, 64'hFFFF_FFFF_1234_5678, 4'h7};
    vec[12] = '{1'b1, 64'h4020, 64'h0, 8'hFF, 64'h0, 4'h7};
    vec[13] = '{1'b0, 64'h4020, 64'h0, 8'h00, 64'h0, 4'h7};
    vec[14] = '{1'b0, 64'h4000, 64'h0, 8'h00, ONES, 4'h7};
    vec[15] = '{1'b1, 64'h8000, 64'h0, 8'hFF, 64'h0, 4'h7};
    vec[16] = '{1'b0, 64'h8000, 64'h0, 8'h00, 64'h0, 4'h7};
    vec[17] = '{1'b0, 64'h0010, 64'h0, 8'h00, 64'h0, 4'h7};
    vec[18] = '{1'b1, 64'h0000, 64'h0, 8'h11, 64'h0, 4'h4};
    vec[19] = '{1'b1, 64'h0010, ONES, 8'hFF, 64'h0, 4'h4};
    vec[20] = '{1'b0, 64'h0008, 64'h0, 8'h00, 64'h0000_0000_0000_0001, 4'h4};

    bus0.valid = 1'b0; bus0.wen = 1'b0; bus0.addr = '0; bus0.wdata = '0; bus0.wmask = '0;
    bus1.valid = 1'b0; bus1.wen = 1'b0; bus1.addr = '0; bus1.wdata = '0; bus1.wmask = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_rvalid", 64'(bus0.rvalid), 64'd0);
    check("reset_rdata", bus0.rdata, 64'd0);
    check("reset_msip", 64'(msip0), 64'd0);
    check("reset_mtip", 64'(mtip0), 64'd0);
    check("reset_mtip_dut1", 64'(mtip1), 64'd0);

    // Prescaler: after k edges out of reset mtime = k/4 and the prescaler holds k%4.
    repeat (20) @(negedge clk);
    op(0, 1'b0, ACLINT_MTIME_OFS, '0, '0, rv, rd);
    check("mtime_after_20_in_4_to_6", 64'(rd >= 64'd4 && rd <= 64'd6), 64'd1);
    repeat (2) @(negedge clk);
    wr(0, "mtime_wr_on_tick", ACLINT_MTIME_OFS, 64'd100, 8'hFF);
    rd_chk(0, "mtime_after_wr", ACLINT_MTIME_OFS, 64'd100);
    repeat (2) @(negedge clk);
    rd_chk(0, "mtime_before_next_tick", ACLINT_MTIME_OFS, 64'd100);
    rd_chk(0, "mtime_after_4_cycles", ACLINT_MTIME_OFS, 64'd101);

    for (int i = 0; i < NV; i++) begin
      op(0, vec[i].wen, vec[i].ofs, vec[i].wdata, vec[i].wmask, rv, rd);
      check($sformatf("vec%0d_rvalid", i), 64'(rv), 64'd1);
      if (!vec[i].wen) check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
      check($sformatf("vec%0d_msip", i), 64'(msip0), 64'(vec[i].exp_msip));
    end
    check("table_mtip", 64'(mtip0), 64'd0);

    // mtip[2] must rise exactly on the edge where mtime reaches 12 (ticks every 4 cycles).
    wr(0, "cmp_mtime10", ACLINT_MTIME_OFS, 64'd10, 8'hFF);
    wr(0, "cmp_mtimecmp2", 64'h4010, 64'd12, 8'hFF);
    check("cmp_mtip_at_10", 64'(mtip0), 64'd0);
    repeat (6) @(negedge clk);
    check("cmp_mtip_at_11", 64'(mtip0), 64'd0);
    @(negedge clk);
    check("cmp_mtip_at_12", 64'(mtip0), 64'h4);
    rd_chk(0, "cmp_mtime_is_12", ACLINT_MTIME_OFS, 64'd12);
    wr(0, "cmp_disarm", 64'h4010, ONES, 8'hFF);
    check("cmp_mtip_cleared", 64'(mtip0), 64'd0);

    // 3-hart, div-1 instance: missing odd hart, out-of-range compare, 64-bit wrap.
    wr(1, "d1_cmp0", 64'h4000, 64'd5, 8'hFF);
    check("d1_mtip_cmp0", 64'(mtip1), 64'h1);
    wr(1, "d1_msip_dw1", 64'h0008, 64'h1_0000_0001, 8'hFF);
    check("d1_msip", 64'(msip1), 64'h4);
    rd_chk(1, "d1_msip_dw1_rd", 64'h0008, 64'h1);
    rd_chk(1, "d1_cmp2", 64'h4010, ONES);
    rd_chk(1, "d1_cmp3_missing", 64'h4018, 64'h0);
    wr(1, "d1_mtime_max", ACLINT_MTIME_OFS, ONES, 8'hFF);
    check("d1_mtip_at_max", 64'(mtip1), 64'h7);
    rd_chk(1, "d1_mtime_max_rd", ACLINT_MTIME_OFS, ONES);
    check("d1_mtip_after_wrap", 64'(mtip1), 64'h0);
    rd_chk(1, "d1_mtime_wrapped", ACLINT_MTIME_OFS, 64'h0);

    // Reset arriving with a read in flight drops the response and restores every register.
    bus0.valid = 1'b1; bus0.wen = 1'b0; bus0.addr = MMAP_ACLINT_BASE + 64'h4000;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_read_rvalid", 64'(bus0.rvalid), 64'd0);
    check("rst_mid_read_rdata", bus0.rdata, 64'd0);
    check("rst_msip", 64'(msip0), 64'd0);
    check("rst_mtip", 64'(mtip0), 64'd0);
    check("rst_msip_dut1", 64'(msip1), 64'd0);
    check("rst_mtip_dut1", 64'(mtip1), 64'd0);
    bus0.valid = 1'b0;
    rst = 1'b0;
    rd_chk(0, "rst_cmp1_restored", 64'h4008, ONES);
    rd_chk(0, "rst_mtime_zero", ACLINT_MTIME_OFS, 64'h0);
    rd_chk(0, "rst_msip_dw1", 64'h0008, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
